// File: rtl/mix_key_add_if.sv
// rtl/mix_key_add_if.sv - stage-to-stage bus for the AES round-completion stage
interface mix_key_add_if;
  logic [127:0] state_in;
  logic [127:0] key_in;
  logic [31:0]  kw3_in;
  logic [7:0]   rcon_in;
  logic         empty_in;
  logic [127:0] state_out;
  logic [127:0] key_out;
  logic [7:0]   rcon_out;
  logic         empty;

  modport master (
    output state_in, key_in, kw3_in, rcon_in, empty_in,
    input  state_out, key_out, rcon_out, empty
  );

  modport slave (
    input  state_in, key_in, kw3_in, rcon_in, empty_in,
    output state_out, key_out, rcon_out, empty
  );
endinterface

// File: rtl/mix_key_add.sv
// rtl/mix_key_add.sv - AES-128 ShiftRows/MixColumns/key expansion/AddRoundKey, 2-cycle pipeline
module mix_key_add #(
  parameter bit LAST_ROUND = 1'b0
) (
  input logic          clock,
  input logic          reset_n,
  mix_key_add_if.slave bus
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0]   sr [16];
  logic [127:0] mix_d, key_d, state_d;
  logic [7:0]   rcon_d;
  logic [31:0]  temp, w4, w5, w6, w7;

  logic [127:0] mix_q, key_q, state_q, key_out_q;
  logic [7:0]   rcon_q, rcon_out_q;
  logic         empty_q, empty_out_q;

  // ShiftRows: row r of column c takes row r of column (c+r) mod 4
  for (genvar i = 0; i < 16; i++) begin : g_sr
    localparam int R   = i % 4;
    localparam int C   = i / 4;
    localparam int SRC = 4 * ((C + R) % 4) + R;
    assign sr[i] = bus.state_in[127-8*SRC -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    if (LAST_ROUND) begin : g_bypass
      assign mix_d[127-32*c -: 32] = {sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]};
    end else begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = sr[4*c];
      assign a1 = sr[4*c+1];
      assign a2 = sr[4*c+2];
      assign a3 = sr[4*c+3];
      assign mix_d[127-32*c -: 32] = {
        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
      };
    end
  end

  // key_in low word already holds SubWord(w3); only the rotation remains
  assign temp   = {bus.key_in[23:0], bus.key_in[31:24]} ^ {bus.rcon_in, 24'h000000};
  assign w4     = bus.key_in[127:96] ^ temp;
  assign w5     = bus.key_in[95:64] ^ w4;
  assign w6     = bus.key_in[63:32] ^ w5;
  assign w7     = bus.kw3_in ^ w6;
  assign key_d  = {w4, w5, w6, w7};
  assign rcon_d = xtime(bus.rcon_in);

  assign state_d = mix_q ^ key_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mix_q       <= '0;
      key_q       <= '0;
      rcon_q      <= '0;
      empty_q     <= 1'b1;
      state_q     <= '0;
      key_out_q   <= '0;
      rcon_out_q  <= '0;
      empty_out_q <= 1'b1;
    end else begin
      mix_q       <= mix_d;
      key_q       <= key_d;
      rcon_q      <= rcon_d;
      empty_q     <= bus.empty_in;
      state_q     <= state_d;
      key_out_q   <= key_q;
      rcon_out_q  <= rcon_q;
      empty_out_q <= empty_q;
    end
  end

  assign bus.state_out = state_q;
  assign bus.key_out   = key_out_q;
  assign bus.rcon_out  = rcon_out_q;
  assign bus.empty     = empty_out_q;

endmodule

// File: tb/tb_mix_key_add.sv
// tb/tb_mix_key_add.sv - bench for mix_key_add, both round flavours driven in lockstep
module tb_mix_key_add;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clock = ~clock;

  mix_key_add_if bus0 ();
  mix_key_add_if bus1 ();

  mix_key_add #(.LAST_ROUND(1'b0)) dut0 (.clock(clock), .reset_n(reset_n), .bus(bus0));
  mix_key_add #(.LAST_ROUND(1'b1)) dut1 (.clock(clock), .reset_n(reset_n), .bus(bus1));

  typedef struct {
    logic [127:0] s;
    logic [127:0] k;
    logic [31:0]  w3;
    logic [7:0]   rc;
    logic         e;
    bit           ok;
  } in_t;

  in_t h1 = '{default: '0};
  in_t h2 = '{default: '0};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input int m);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int b = 0; b < 2; b++) begin
      if (((m >> b) & 1) != 0) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic model(input in_t x, input bit last,
                       output logic [127:0] so, output logic [127:0] ko, output logic [7:0] ro);
    logic [7:0]  a [4][4];
    logic [7:0]  b [4][4];
    logic [7:0]  m [4][4];
    logic [31:0] kw [4];
    logic [31:0] nw [4];
    logic [31:0] sub, t;
    int coef [4] = '{2, 3, 1, 1};
    for (int i = 0; i < 16; i++) a[i%4][i/4] = 8'(x.s >> (8 * (15 - i)));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) b[r][c] = a[r][(c + r) % 4];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        m[r][c] = 8'h00;
        for (int k = 0; k < 4; k++) m[r][c] ^= gmul(b[k][c], coef[(k - r + 4) % 4]);
        if (last) m[r][c] = b[r][c];
      end
    for (int w = 0; w < 4; w++) kw[w] = 32'(x.k >> (32 * (3 - w)));
    sub = kw[3];
    t = {sub[23:0], sub[31:24]} ^ {x.rc, 24'h0};
    nw[0] = kw[0] ^ t;
    nw[1] = kw[1] ^ nw[0];
    nw[2] = kw[2] ^ nw[1];
    nw[3] = x.w3 ^ nw[2];
    so = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) so = {so[119:0], m[r][c]};
    ko = {nw[0], nw[1], nw[2], nw[3]};
    so ^= ko;
    ro = gmul(x.rc, 2);
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h1.ok = 1'b0;
      h2.ok = 1'b0;
    end else begin
      h2 = h1;
      h1 = '{bus0.state_in, bus0.key_in, bus0.kw3_in, bus0.rcon_in, bus0.empty_in, 1'b1};
    end
  end

  // Scoreboard: outputs must reflect the inputs captured two edges back
  always @(negedge clock) begin
    logic [127:0] so0, ko0, so1, ko1;
    logic [7:0]   ro0, ro1;
    if (reset_n) begin
      if (h2.ok) begin
        model(h2, 1'b0, so0, ko0, ro0);
        model(h2, 1'b1, so1, ko1, ro1);
        chk("sb0_state", bus0.state_out, so0);
        chk("sb0_key", bus0.key_out, ko0);
        chk("sb0_rcon", 128'(bus0.rcon_out), 128'(ro0));
        chk("sb0_empty", 128'(bus0.empty), 128'(h2.e));
        chk("sb1_state", bus1.state_out, so1);
        chk("sb1_key", bus1.key_out, ko1);
        chk("sb1_rcon", 128'(bus1.rcon_out), 128'(ro1));
        chk("sb1_empty", 128'(bus1.empty), 128'(h2.e));
      end else begin
        chk("sb_idle_state", bus0.state_out | bus1.state_out, 128'h0);
        chk("sb_idle_key", bus0.key_out | bus1.key_out, 128'h0);
        chk("sb_idle_rcon", 128'(bus0.rcon_out | bus1.rcon_out), 128'h0);
        chk("sb_idle_empty", 128'({bus0.empty, bus1.empty}), 128'h3);
      end
    end
  end

  task automatic drive(input logic [127:0] s, input logic [127:0] k, input logic [31:0] w3,
                       input logic [7:0] rc, input logic e);
    @(negedge clock);
    bus0.state_in = s;  bus1.state_in = s;
    bus0.key_in   = k;  bus1.key_in   = k;
    bus0.kw3_in   = w3; bus1.kw3_in   = w3;
    bus0.rcon_in  = rc; bus1.rcon_in  = rc;
    bus0.empty_in = e;  bus1.empty_in = e;
  endtask

  task automatic drive_random();
    drive({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
          $urandom, 8'($urandom), 1'($urandom));
  endtask

  localparam logic [127:0] S1 = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf71588018a84eb;
  localparam logic [127:0] S10 = 128'he9098972cb31075f3d327d94af2e2cb5;
  localparam logic [127:0] K10 = 128'hac7766f319fadc2128d129415b4a639f;

  initial begin
    in_t          pin;
    logic [127:0] ps, pk;
    logic [7:0]   pr;

    bus0.state_in = '0; bus1.state_in = '0;
    bus0.key_in   = '0; bus1.key_in   = '0;
    bus0.kw3_in   = '0; bus1.kw3_in   = '0;
    bus0.rcon_in  = '0; bus1.rcon_in  = '0;
    bus0.empty_in = 1'b1; bus1.empty_in = 1'b1;

    pin = '{S1, K1, 32'h09cf4f3c, 8'h01, 1'b0, 1'b1};
    model(pin, 1'b0, ps, pk, pr);
    chk("model_r1_state", ps, 128'ha49c7ff2689f352b6b5bea43026a5049);
    chk("model_r1_key", pk, 128'ha0fafe1788542cb123a339392a6c7605);
    pin = '{S10, K10, 32'h575c006e, 8'h36, 1'b0, 1'b1};
    model(pin, 1'b1, ps, pk, pr);
    chk("model_r10_state", ps, 128'h3925841d02dc09fbdc118597196a0b32);
    chk("model_r10_rcon", 128'(pr), 128'h6c);

    repeat (2) @(negedge clock);
    chk("reset_state", bus0.state_out, 128'h0);
    chk("reset_empty", 128'(bus0.empty), 128'h1);
    reset_n = 1'b1;

    // round 1 on the full-round instance
    drive(S1, K1, 32'h09cf4f3c, 8'h01, 1'b0);
    drive(S1, K1, 32'h09cf4f3c, 8'h01, 1'b1);
    drive(S1, K1, 32'h09cf4f3c, 8'h01, 1'b1);
    chk("r1_state", bus0.state_out, 128'ha49c7ff2689f352b6b5bea43026a5049);
    chk("r1_key", bus0.key_out, 128'ha0fafe1788542cb123a339392a6c7605);
    chk("r1_rcon", 128'(bus0.rcon_out), 128'h02);
    chk("r1_empty", 128'(bus0.empty), 128'h0);

    // round 10 on the final-round instance
    drive(S10, K10, 32'h575c006e, 8'h36, 1'b0);
    drive(S10, K10, 32'h575c006e, 8'h36, 1'b1);
    drive(S10, K10, 32'h575c006e, 8'h36, 1'b1);
    chk("r10_state", bus1.state_out, 128'h3925841d02dc09fbdc118597196a0b32);
    chk("r10_key", bus1.key_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("r10_rcon", 128'(bus1.rcon_out), 128'h6c);

    // valid, bubble, valid with rcon wrap on consecutive cycles
    drive(S1, K1, 32'h09cf4f3c, 8'h01, 1'b0);
    drive(128'h0123456789abcdef0123456789abcdef, K10, 32'h11111111, 8'h55, 1'b1);
    drive(S1, K1, 32'h09cf4f3c, 8'h80, 1'b0);
    chk("stream_empty0", 128'(bus0.empty), 128'h0);
    chk("stream_state0", bus0.state_out, 128'ha49c7ff2689f352b6b5bea43026a5049);
    drive(S1, K1, 32'h09cf4f3c, 8'h00, 1'b1);
    chk("stream_empty1", 128'(bus0.empty), 128'h1);
    drive(S1, K1, 32'h09cf4f3c, 8'h00, 1'b1);
    chk("stream_empty2", 128'(bus0.empty), 128'h0);
    chk("stream_rcon2", 128'(bus0.rcon_out), 128'h1b);
    drive(S1, K1, 32'h09cf4f3c, 8'h00, 1'b1);
    chk("rcon_zero", 128'(bus0.rcon_out), 128'h00);

    for (int i = 0; i < 600; i++) drive_random();

    // asynchronous reset mid-stream
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_state", bus0.state_out | bus1.state_out, 128'h0);
    chk("async_rst_key", bus0.key_out | bus1.key_out, 128'h0);
    chk("async_rst_rcon", 128'(bus0.rcon_out | bus1.rcon_out), 128'h0);
    chk("async_rst_empty", 128'({bus0.empty, bus1.empty}), 128'h3);
    drive(S1, K1, 32'h09cf4f3c, 8'h01, 1'b1);
    drive(S1, K1, 32'h09cf4f3c, 8'h01, 1'b1);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(S1, K1, 32'h09cf4f3c, 8'h01, 1'b1);
      chk("post_rst_empty", 128'(bus0.empty), 128'h1);
    end

    for (int i = 0; i < 400; i++) drive_random();
    repeat (3) drive(S1, K1, 32'h09cf4f3c, 8'h01, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
